// File: rtl/baccarat_pkg.sv
// rtl/baccarat_pkg.sv - state encoding, rule constants and load decode for the baccarat controller
package baccarat_pkg;

    // Dealing/scoring states; encoding is fixed so a debug view is stable
    typedef enum logic [3:0] {
        Sa = 4'd0,  // idle after reset
        Sb = 4'd1,  // load player card 1
        Sc = 4'd2,  // load dealer card 1
        Sd = 4'd3,  // load player card 2
        Se = 4'd4,  // load dealer card 2, natural / player-draw decision
        Sf = 4'd5,  // load player card 3, banker-draw decision
        Sg = 4'd6,  // load dealer card 3
        Sh = 4'd7   // hand over, lights valid
    } state_t;

    // Lowest natural score (8 or 9 ends the hand immediately)
    localparam logic [3:0] NATURAL_LO   = 4'd8;
    // Player stands on this score or higher (6 or 7)
    localparam logic [3:0] PLAYER_STAND = 4'd6;

    // Load strobe vector for a state, ordered
    // {pcard1, dcard1, pcard2, dcard2, pcard3, dcard3}
    function automatic logic [5:0] load_decode(input state_t s);
        logic [5:0] v;
        v = 6'b000000;
        case (s)
            Sb:      v = 6'b100000;
            Sc:      v = 6'b010000;
            Sd:      v = 6'b001000;
            Se:      v = 6'b000100;
            Sf:      v = 6'b000010;
            Sg:      v = 6'b000001;
            default: v = 6'b000000;
        endcase
        return v;
    endfunction

endpackage

// File: rtl/banker_draw_rule.sv
// rtl/banker_draw_rule.sv - banker third-card rule, combinational
//
// Ports:
//   dscore [3:0] in   banker score after two cards
//   pcard3 [3:0] in   value of the player's third card
//   draw         out  1 = banker takes a third card
module banker_draw_rule (
    input  logic [3:0] dscore,
    input  logic [3:0] pcard3,
    output logic       draw
);

    always_comb begin
        draw = 1'b0;
        case (dscore)
            4'd0, 4'd1, 4'd2: draw = 1'b1;
            4'd3:             draw = (pcard3 != 4'd8);
            4'd4:             draw = (pcard3 >= 4'd2) && (pcard3 <= 4'd7);
            4'd5:             draw = (pcard3 >= 4'd4) && (pcard3 <= 4'd7);
            4'd6:             draw = (pcard3 >= 4'd6) && (pcard3 <= 4'd7);
            // 7 and above, including out-of-range scores, always stand
            default:          draw = 1'b0;
        endcase
    end

endmodule

// File: rtl/baccarat_statemachine.sv
// rtl/baccarat_statemachine.sv - baccarat dealing/scoring controller
//
// Sequences card loads for player and dealer, applies the natural,
// player-third-card and banker-third-card rules, and drives win lights.
//
// Ports:
//   slow_clock       in   clock, all state updates on posedge
//   resetb           in   synchronous reset, active high
//   dscore [3:0]     in   dealer hand score
//   pscore [3:0]     in   player hand score
//   pcard3 [3:0]     in   player's third card value
//   load_pcard1..3   out  player card load strobes
//   load_dcard1..3   out  dealer card load strobes
//   player_win_light out  player-wins LED
//   dealer_win_light out  dealer-wins LED
//   state_dbg [3:0]  out  present state (only with STATE_DEBUG_EN defined)
//
// Build option: STATE_DEBUG_EN
module baccarat_statemachine
    import baccarat_pkg::*;
(
    input  logic       slow_clock,
    input  logic       resetb,
    input  logic [3:0] dscore,
    input  logic [3:0] pscore,
    input  logic [3:0] pcard3,
    output logic       load_pcard1,
    output logic       load_pcard2,
    output logic       load_pcard3,
    output logic       load_dcard1,
    output logic       load_dcard2,
    output logic       load_dcard3,
    output logic       player_win_light,
`ifdef STATE_DEBUG_EN
    output logic       dealer_win_light,
    output logic [3:0] state_dbg
`else
    output logic       dealer_win_light
`endif
);

    state_t     present_state;
    state_t     next_state;
    logic [5:0] loads;
    logic       banker_draw;
    logic       natural;

    banker_draw_rule u_banker_draw_rule (
        .dscore (dscore),
        .pcard3 (pcard3),
        .draw   (banker_draw)
    );

    assign natural = ((pscore >= NATURAL_LO) && (pscore <= NATURAL_LO + 4'd1)) ||
                     ((dscore >= NATURAL_LO) && (dscore <= NATURAL_LO + 4'd1));

    always_comb begin
        next_state = present_state;
        case (present_state)
            Sa: next_state = Sb;
            Sb: next_state = Sc;
            Sc: next_state = Sd;
            Sd: next_state = Se;
            Se: begin
                if (natural)
                    next_state = Sh;
                else if (pscore < PLAYER_STAND)
                    next_state = Sf;
                else if (pscore <= PLAYER_STAND + 4'd1)
                    next_state = (dscore < PLAYER_STAND) ? Sg : Sh;
                else
                    // Invalid player score: hold and keep dcard2 loading
                    next_state = Se;
            end
            Sf:      next_state = banker_draw ? Sg : Sh;
            Sg:      next_state = Sh;
            Sh:      next_state = Sh;
            default: next_state = Sa;
        endcase
    end

    // Loads are registered from the next state so they stay a pure
    // function of present_state while coming straight off flops.
    always_ff @(posedge slow_clock) begin
        if (resetb) begin
            present_state <= Sa;
            loads         <= 6'b000000;
        end else begin
            present_state <= next_state;
            loads         <= load_decode(next_state);
        end
    end

    assign {load_pcard1, load_dcard1, load_pcard2,
            load_dcard2, load_pcard3, load_dcard3} = loads;

    // Lights follow score changes in Sh without waiting for a clock
    always_comb begin
        player_win_light = 1'b0;
        dealer_win_light = 1'b0;
        if (present_state == Sh) begin
            player_win_light = (pscore >= dscore);
            dealer_win_light = (dscore >= pscore);
        end
    end

`ifdef STATE_DEBUG_EN
    assign state_dbg = present_state;
`endif

endmodule

// File: tb/tb_baccarat_statemachine.sv
// tb/tb_baccarat_statemachine.sv - directed vector bench for baccarat_statemachine
module tb_baccarat_statemachine;

    logic       slow_clock = 1'b0;
    logic       resetb = 1'b1;
    logic [3:0] dscore = 4'd0;
    logic [3:0] pscore = 4'd0;
    logic [3:0] pcard3 = 4'd0;
    logic       load_pcard1, load_pcard2, load_pcard3;
    logic       load_dcard1, load_dcard2, load_dcard3;
    logic       player_win_light, dealer_win_light;

    int total = 0;
    int bad   = 0;

    always #5 slow_clock = ~slow_clock;

    baccarat_statemachine dut (
        .slow_clock       (slow_clock),
        .resetb           (resetb),
        .dscore           (dscore),
        .pscore           (pscore),
        .pcard3           (pcard3),
        .load_pcard1      (load_pcard1),
        .load_pcard2      (load_pcard2),
        .load_pcard3      (load_pcard3),
        .load_dcard1      (load_dcard1),
        .load_dcard2      (load_dcard2),
        .load_dcard3      (load_dcard3),
        .player_win_light (player_win_light),
        .dealer_win_light (dealer_win_light)
    );

    logic [5:0] ld_act;
    assign ld_act = {load_pcard1, load_dcard1, load_pcard2,
                     load_dcard2, load_pcard3, load_dcard3};

    typedef struct {
        bit         clk;
        bit         rst;
        logic [3:0] ps;
        logic [3:0] ds;
        logic [3:0] pc;
        logic [5:0] ld;
        logic       pw;
        logic       dw;
    } row_t;

    row_t rows[$];

    // Banker draw masks indexed by dscore, bit n = pcard3 value n
    logic [9:0] draw_mask [0:15];

    task automatic add(input bit c, input bit r, input logic [3:0] ps, input logic [3:0] ds,
                       input logic [3:0] pc, input logic [5:0] ld, input logic pw, input logic dw);
        row_t t;
        t.clk = c; t.rst = r; t.ps = ps; t.ds = ds; t.pc = pc;
        t.ld = ld; t.pw = pw; t.dw = dw;
        rows.push_back(t);
    endtask

    // Reset, then the four fixed dealing states Sb..Se
    task automatic add_deal(input logic [3:0] ps, input logic [3:0] ds, input logic [3:0] pc);
        add(1, 1, ps, ds, pc, 6'b000000, 0, 0);
        add(1, 0, ps, ds, pc, 6'b100000, 0, 0);
        add(1, 0, ps, ds, pc, 6'b010000, 0, 0);
        add(1, 0, ps, ds, pc, 6'b001000, 0, 0);
        add(1, 0, ps, ds, pc, 6'b000100, 0, 0);
    endtask

    task automatic check(input string name, input logic [5:0] act, input logic [5:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %b want %b", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge slow_clock);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 16; i++) draw_mask[i] = 10'h000;
        draw_mask[0] = 10'h3FF;
        draw_mask[1] = 10'h3FF;
        draw_mask[2] = 10'h3FF;
        draw_mask[3] = 10'h2FF;
        draw_mask[4] = 10'h0FC;
        draw_mask[5] = 10'h0F0;
        draw_mask[6] = 10'h0C0;

        // Natural for dealer, then tie lights both without a clock
        add_deal(5, 8, 0);
        add(1, 0, 5, 8, 0, 6'b000000, 0, 1);
        add(0, 0, 8, 8, 0, 6'b000000, 1, 1);
        add(0, 0, 3, 2, 0, 6'b000000, 1, 0);
        add(1, 0, 3, 2, 0, 6'b000000, 1, 0);
        // Player draws, banker stands on 4 vs pcard3=1
        add_deal(0, 4, 1);
        add(1, 0, 0, 4, 1, 6'b000010, 0, 0);
        add(1, 0, 0, 4, 1, 6'b000000, 0, 1);
        // Player draws, banker draws on 4 vs pcard3=5
        add_deal(0, 4, 5);
        add(1, 0, 0, 4, 5, 6'b000010, 0, 0);
        add(1, 0, 0, 4, 5, 6'b000001, 0, 0);
        add(1, 0, 0, 4, 5, 6'b000000, 0, 1);
        // Player stands on 6, banker draws on 5
        add_deal(6, 5, 0);
        add(1, 0, 6, 5, 0, 6'b000001, 0, 0);
        add(1, 0, 6, 5, 0, 6'b000000, 1, 0);
        // Both stand: straight to Sh
        add_deal(7, 6, 0);
        add(1, 0, 7, 6, 0, 6'b000000, 1, 0);
        // Out-of-range player score holds in Se
        add_deal(10, 3, 0);
        add(1, 0, 10, 3, 0, 6'b000100, 0, 0);
        add(1, 0, 10, 3, 0, 6'b000100, 0, 0);
        // Reset while in Sg
        add_deal(6, 5, 0);
        add(1, 0, 6, 5, 0, 6'b000001, 0, 0);
        add(1, 1, 6, 5, 0, 6'b000000, 0, 0);
        add(1, 0, 6, 5, 0, 6'b100000, 0, 0);

        foreach (rows[i]) begin
            resetb = rows[i].rst;
            pscore = rows[i].ps;
            dscore = rows[i].ds;
            pcard3 = rows[i].pc;
            if (rows[i].clk) tick();
            else #1;
            check($sformatf("row%0d_loads", i), ld_act, rows[i].ld);
            check($sformatf("row%0d_lights", i), {4'b0, player_win_light, dealer_win_light},
                  {4'b0, rows[i].pw, rows[i].dw});
        end

        // Banker rule sweep: player 3 always draws, banker 0..12 without naturals
        for (int ds = 0; ds <= 12; ds++) begin
            if (ds == 8 || ds == 9) continue;
            for (int pc = 0; pc <= 9; pc++) begin
                logic [9:0] m;
                logic [5:0] exp_ld;
                pscore = 4'd3;
                dscore = ds[3:0];
                pcard3 = pc[3:0];
                resetb = 1'b1;
                tick();
                resetb = 1'b0;
                repeat (4) tick();
                tick();
                check($sformatf("sweep_d%0d_p%0d_sf", ds, pc), ld_act, 6'b000010);
                tick();
                m = draw_mask[ds];
                exp_ld = m[pc] ? 6'b000001 : 6'b000000;
                check($sformatf("sweep_d%0d_p%0d_draw", ds, pc), ld_act, exp_ld);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
